// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction codes and helpers shared by the snake input conditioner
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // 180-degree reversal: the codes are laid out so that opposites differ in both bits
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b11);
    endfunction

    // One-hot vector in the same bit map as the raw buttons
    function automatic logic [3:0] onehot(input dir_t d);
        logic [3:0] r;
        r = 4'b0001 << d;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce counter and press-edge detector for one button
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic clear_n,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0_q, sync1_q;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has differed from the stable state for DEBOUNCE_CYCLES cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync1_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_d & ~stable_q;
    end

    // Synchroniser, debounce and edge registers; game restart deliberately does not touch these
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync0_q  <= 1'b0;
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync0_q  <= btn_i;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/snake_dir_input.sv
// rtl/snake_dir_input.sv - button-to-heading conditioner with 2-deep turn queue; option macro SNAKE_REVERSE_FILTER_EN
module snake_dir_input
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned DROP_W          = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [3:0]        btn,
    input  logic              move_tick,
    input  logic              game_clear,
    output logic [1:0]        heading,
    output logic [3:0]        direction,
    output logic [1:0]        pending,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [3:0]        press;
    dir_t              heading_q, heading_d;
    dir_t              q0_q, q0_d, q1_q, q1_d;
    logic [1:0]        pend_q, pend_d;
    logic [3:0]        dir_q, dir_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    dir_t              press_dir, ref_dir;
    logic              press_vld, turn_ok, take, pop, push, drop;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .clear_n(clear_n),
            .btn_i  (btn[i]),
            .press_o(press[i])
        );
    end

    // Pick a single press per cycle: right > left > down > up
    always_comb begin
        press_vld = 1'b1;
        press_dir = DIR_RIGHT;
        if (press[3])      press_dir = DIR_RIGHT;
        else if (press[0]) press_dir = DIR_LEFT;
        else if (press[1]) press_dir = DIR_DOWN;
        else if (press[2]) press_dir = DIR_UP;
        else               press_vld = 1'b0;
    end

    // Turns are judged against the last queued turn, or the heading when nothing is queued
    assign ref_dir = (pend_q == 2'd0) ? heading_q :
                     (pend_q == 2'd1) ? q0_q : q1_q;

`ifdef SNAKE_REVERSE_FILTER_EN
    assign turn_ok = (press_dir != ref_dir) && (press_dir != opposite(ref_dir));
`else
    assign turn_ok = (press_dir != ref_dir);
`endif

    assign take = press_vld & turn_ok;
    assign pop  = move_tick & (pend_q != 2'd0);
    assign push = take & ((pend_q != 2'd2) | pop);
    assign drop = take & ~push;

    // Queue, heading and drop counter update; game restart overrides everything else
    always_comb begin
        heading_d = heading_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        if (game_clear) begin
            heading_d = DIR_RIGHT;
            pend_d    = 2'd0;
            drop_d    = '0;
        end else begin
            if (pop) heading_d = q0_q;
            case ({push, pop})
                2'b10: begin
                    if (pend_q == 2'd0) q0_d = press_dir;
                    else                q1_d = press_dir;
                    pend_d = pend_q + 2'd1;
                end
                2'b01: begin
                    q0_d   = q1_q;
                    pend_d = pend_q - 2'd1;
                end
                2'b11: begin
                    if (pend_q == 2'd1) begin
                        q0_d = press_dir;
                    end else begin
                        q0_d = q1_q;
                        q1_d = press_dir;
                    end
                end
                default: ;
            endcase
            if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);
        end
        dir_d = onehot(heading_d);
    end

    // State registers; the one-hot vector is registered alongside the heading so both move together
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            heading_q <= DIR_RIGHT;
            dir_q     <= 4'b1000;
            q0_q      <= DIR_LEFT;
            q1_q      <= DIR_LEFT;
            pend_q    <= 2'd0;
            drop_q    <= '0;
        end else begin
            heading_q <= heading_d;
            dir_q     <= dir_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
        end
    end

    assign heading   = heading_q;
    assign direction = dir_q;
    assign pending   = pend_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// tb/tb_snake_dir_input.sv - scoreboard bench for snake_dir_input with DEBOUNCE_CYCLES=4
module tb_snake_dir_input;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic       clk        = 1'b0;
    logic       clk_en     = 1'b1;
    logic       clear_n    = 1'b1;
    logic [3:0] btn        = 4'b0000;
    logic       move_tick  = 1'b0;
    logic       game_clear = 1'b0;
    logic [1:0] heading;
    logic [3:0] direction;
    logic [1:0] pending;
    logic [7:0] drop_cnt;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last  = 16'hFFFF;

    snake_dir_input #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .DROP_W         (8)
    ) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .btn       (btn),
        .move_tick (move_tick),
        .game_clear(game_clear),
        .heading   (heading),
        .direction (direction),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic expect_st(input string nm, input logic [1:0] h, input logic [3:0] d,
                             input logic [1:0] p, input logic [7:0] dc);
        exp_t e;
        e.name = nm;
        e.val  = {h, d, p, dc};
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input logic [3:0] m);
        btn = m;
        tick(10);
        btn = 4'b0000;
        tick(10);
    endtask

    task automatic pulse_move();
        move_tick = 1'b1;
        tick(1);
        move_tick = 1'b0;
        tick(3);
    endtask

    task automatic pulse_clear(input logic with_move);
        game_clear = 1'b1;
        move_tick  = with_move;
        tick(1);
        game_clear = 1'b0;
        move_tick  = 1'b0;
        tick(3);
    endtask

    // Monitor: every change of the output tuple is matched against the next expected state
    always begin
        logic [15:0] cur;
        exp_t        e;
        @(negedge clk or negedge clear_n);
        #1;
        cur = {heading, direction, pending, drop_cnt};
        if (cur !== last) begin
            last  = cur;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_change: got h=%b dir=%b pend=%0d drop=%0d, required no change",
                         cur[15:14], cur[13:10], cur[9:8], cur[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.val) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got h=%b dir=%b pend=%0d drop=%0d, required h=%b dir=%b pend=%0d drop=%0d",
                             e.name, cur[15:14], cur[13:10], cur[9:8], cur[7:0],
                             e.val[15:14], e.val[13:10], e.val[9:8], e.val[7:0]);
                end
            end
        end
    end

    initial begin
        // 1: reset state, then a short glitch that must not register
        expect_st("reset", 2'b11, 4'b1000, 2'd0, 8'd0);
        #1 clear_n = 1'b0;
        tick(3);
        clear_n = 1'b1;
        tick(2);
        btn = 4'b0010;
        tick(2);
        btn = 4'b0000;
        tick(12);

        // 2: down press queues, move_tick applies it
        expect_st("down_push", 2'b11, 4'b1000, 2'd1, 8'd0);
        press_btn(4'b0010);
        expect_st("down_pop", 2'b01, 4'b0010, 2'd0, 8'd0);
        pulse_move();

        // 3: reversal from heading right
        expect_st("clear_a", 2'b11, 4'b1000, 2'd0, 8'd0);
        pulse_clear(1'b0);
`ifndef SNAKE_REVERSE_FILTER_EN
        expect_st("rev_push", 2'b11, 4'b1000, 2'd1, 8'd0);
`endif
        press_btn(4'b0001);
`ifndef SNAKE_REVERSE_FILTER_EN
        expect_st("rev_pop", 2'b00, 4'b0001, 2'd0, 8'd0);
        pulse_move();
        expect_st("clear_b", 2'b11, 4'b1000, 2'd0, 8'd0);
        pulse_clear(1'b0);
`endif

        // 4: fill queue, overflow drop, drain
        expect_st("q_down", 2'b11, 4'b1000, 2'd1, 8'd0);
        press_btn(4'b0010);
        expect_st("q_left", 2'b11, 4'b1000, 2'd2, 8'd0);
        press_btn(4'b0001);
        expect_st("q_drop", 2'b11, 4'b1000, 2'd2, 8'd1);
        press_btn(4'b0100);
        expect_st("pop1", 2'b01, 4'b0010, 2'd1, 8'd1);
        pulse_move();
        expect_st("pop2", 2'b00, 4'b0001, 2'd0, 8'd1);
        pulse_move();

        // 5: simultaneous right+up with heading down: right wins
        expect_st("to_down_push", 2'b00, 4'b0001, 2'd1, 8'd1);
        press_btn(4'b0010);
        expect_st("to_down_pop", 2'b01, 4'b0010, 2'd0, 8'd1);
        pulse_move();
        expect_st("prio_right", 2'b01, 4'b0010, 2'd1, 8'd1);
        press_btn(4'b1100);

        // 6: full queue, then game_clear beats move_tick
        expect_st("fill_up", 2'b01, 4'b0010, 2'd2, 8'd1);
        press_btn(4'b0100);
        expect_st("clear_vs_move", 2'b11, 4'b1000, 2'd0, 8'd0);
        pulse_clear(1'b1);

        // async reset mid-debounce with the clock stopped
        expect_st("pre_async", 2'b11, 4'b1000, 2'd1, 8'd0);
        press_btn(4'b0010);
        btn = 4'b0001;
        tick(3);
        @(negedge clk);
        clk_en = 1'b0;
        expect_st("async_reset", 2'b11, 4'b1000, 2'd0, 8'd0);
        #2 clear_n = 1'b0;
        #5 btn = 4'b0000;
        clear_n = 1'b1;
        #5 clk_en = 1'b1;
        tick(15);
        expect_st("post_reset", 2'b11, 4'b1000, 2'd1, 8'd0);
        press_btn(4'b0010);
        tick(5);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s: got no such output change, required h=%b dir=%b pend=%0d drop=%0d",
                     e.name, e.val[15:14], e.val[13:10], e.val[9:8], e.val[7:0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
